// File: rtl/servant_spi_mem_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-SPI RAM controller: opcodes, FSM
// encoding, byte-count width and byte-lane helper functions.
package servant_spi_mem_ctrl_pkg;

    localparam logic [7:0] DEF_OP_READ  = 8'h03;
    localparam logic [7:0] DEF_OP_WRITE = 8'h02;
    localparam int         BCNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_GAP
    } state_t;

    function automatic logic [BCNT_W-1:0] sel_popcount(input logic [3:0] sel);
        return BCNT_W'(sel[0]) + BCNT_W'(sel[1]) + BCNT_W'(sel[2]) + BCNT_W'(sel[3]);
    endfunction

    function automatic logic [1:0] sel_first_lane(input logic [3:0] sel);
        if (sel[0])      return 2'd0;
        else if (sel[1]) return 2'd1;
        else if (sel[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    // After shifting out the zero lanes, a contiguous mask is of the form 0..01..1.
    function automatic logic sel_contiguous(input logic [3:0] sel);
        logic [3:0] m;
        m = sel >> sel_first_lane(sel);
        return (sel != 4'd0) && ((m & (m + 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/servant_spi_byte_xfer.sv
// SPI mode-0 byte shifter: generates SCK, shifts one byte out MSB first on the
// falling edge and samples MISO on the rising edge. A start in the done cycle chains bytes.
module servant_spi_byte_xfer #(
    parameter int CLOCK_DIVIDER = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);
    localparam int DW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;

    logic [DW-1:0] div_cnt;
    logic [3:0]    tog_cnt;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          tick;

    assign tick    = busy && (div_cnt == DW'(CLOCK_DIVIDER - 1));
    assign done    = tick && (tog_cnt == 4'd15);
    assign rx_byte = rx_sh;
    assign mosi    = tx_sh[7];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tog_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            busy    <= 1'b0;
            sck     <= 1'b0;
        end else if (!busy) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                tx_sh   <= tx_byte;
                tog_cnt <= '0;
            end
        end else if (tick) begin
            div_cnt <= '0;
            tog_cnt <= tog_cnt + 4'd1;
            if (!sck) begin
                sck   <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso};
            end else begin
                sck <= 1'b0;
                // Last falling edge: either load the next byte or park MOSI low.
                if (tog_cnt == 4'd15) begin
                    if (start) begin
                        tx_sh <= tx_byte;
                    end else begin
                        busy  <= 1'b0;
                        tx_sh <= '0;
                    end
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/servant_spi_mem_ctrl.sv
// Wishbone slave that serializes each 32-bit access into one CS-framed SPI RAM
// transaction (opcode, address, data) and reassembles read data little-endian.
module servant_spi_mem_ctrl
    import servant_spi_mem_ctrl_pkg::*;
#(
    parameter int         ADDR_BYTES    = 3,
    parameter int         CLOCK_DIVIDER = 2,
    parameter int         CS_GAP        = 2,
    parameter logic [7:0] OP_READ       = DEF_OP_READ,
    parameter logic [7:0] OP_WRITE      = DEF_OP_WRITE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wb_sel,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic [31:0] rd_data,
    output logic        wb_ack,
    output logic        spi_sck,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    state_t            state, state_nxt;
    logic [BCNT_W-1:0] cnt;
    logic [BCNT_W-1:0] nbytes_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [31:0]       rd_buf;
    logic [1:0]        lane_q;
    logic              we_q;
    logic [15:0]       gap_cnt;

    logic              start, latch;
    logic [7:0]        tx_byte;
    logic              busy, done;
    logic [7:0]        rx_byte;

    logic              unused_ok;
    assign unused_ok = &{1'b0, address[1:0]};

    function automatic logic [7:0] addr_byte(input int k);
        return 8'(addr_q >> (8 * (ADDR_BYTES - 1 - k)));
    endfunction

    function automatic logic [7:0] data_byte(input int k);
        return we_q ? 8'(data_q >> (8 * (int'(lane_q) + k))) : 8'h00;
    endfunction

    servant_spi_byte_xfer #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_xfer (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .tx_byte (tx_byte),
        .miso    (spi_miso),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Each byte's successor is handed to the shifter in its done cycle so
    // bytes within a frame run back to back with no idle SCK periods.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        latch     = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            ST_IDLE: if (wb_cyc && !wb_ack && !busy) begin
                latch     = 1'b1;
                start     = 1'b1;
                tx_byte   = wb_we ? OP_WRITE : OP_READ;
                state_nxt = ST_CMD;
            end
            ST_CMD: if (done) begin
                start     = 1'b1;
                tx_byte   = addr_byte(0);
                state_nxt = ST_ADDR;
            end
            ST_ADDR: if (done) begin
                start = 1'b1;
                if (cnt == BCNT_W'(ADDR_BYTES - 1)) begin
                    tx_byte   = data_byte(0);
                    state_nxt = ST_DATA;
                end else begin
                    tx_byte = addr_byte(int'(cnt) + 1);
                end
            end
            ST_DATA: if (done) begin
                if (cnt == nbytes_q - BCNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    start   = 1'b1;
                    tx_byte = data_byte(int'(cnt) + 1);
                end
            end
            ST_DONE: state_nxt = ST_GAP;
            ST_GAP:  if (int'(gap_cnt) >= CS_GAP - 1) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            nbytes_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_buf   <= '0;
            lane_q   <= '0;
            we_q     <= 1'b0;
            gap_cnt  <= '0;
            spi_ss   <= 1'b1;
            wb_ack   <= 1'b0;
            rd_data  <= '0;
        end else begin
            wb_ack  <= (state == ST_DONE);
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (latch) begin
                // Writes start at the first selected lane; reads always fetch the whole word.
                addr_q   <= {address[31:2], wb_we ? sel_first_lane(wb_sel) : 2'b00};
                data_q   <= wr_data;
                we_q     <= wb_we;
                lane_q   <= sel_first_lane(wb_sel);
                nbytes_q <= wb_we ? sel_popcount(wb_sel) : BCNT_W'(4);
                cnt      <= '0;
                spi_ss   <= 1'b0;
            end else if (done) begin
                cnt <= (state_nxt != state) ? '0 : cnt + BCNT_W'(1);
                if (state == ST_DATA) rd_buf[{cnt[1:0], 3'b000} +: 8] <= rx_byte;
            end
            if (state == ST_DONE) begin
                spi_ss <= 1'b1;
                if (!we_q) rd_data <= rd_buf;
            end
        end
    end

`ifndef SYNTHESIS
    sel_legal: assert property (@(posedge clock) disable iff (!reset_n)
        (state == ST_IDLE && wb_cyc && !wb_ack) |-> sel_contiguous(wb_sel));
`endif

endmodule

// File: tb/tb_servant_spi_mem_ctrl.sv
// Bench for servant_spi_mem_ctrl: behavioural 23LC-style SPI RAM, directed accesses,
// and scoreboards for acks (rd_data, latency) and for MOSI frame contents.
module tb_servant_spi_mem_ctrl;
    localparam int CS_GAP = 2;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wb_sel  = 4'hF;
    logic        wb_we   = 1'b0;
    logic        wb_cyc  = 1'b0;
    logic [31:0] rd_data;
    logic        wb_ack, spi_sck, spi_ss, spi_mosi;
    logic        spi_miso = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc_n++;

    servant_spi_mem_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .address  (address),
        .wr_data  (wr_data),
        .wb_sel   (wb_sel),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .rd_data  (rd_data),
        .wb_ack   (wb_ack),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // SPI RAM model (256 bytes, address taken from the last address byte)
    logic [7:0] mem [256];
    logic [7:0] fr [$];
    logic [7:0] sh = 8'h00;
    logic [7:0] ad = 8'h00;
    logic [7:0] cur;
    int         bitc = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        mem[8'h44] = 8'h01; mem[8'h45] = 8'h02; mem[8'h46] = 8'h03; mem[8'h47] = 8'h04;
    end

    always @(negedge spi_ss) begin
        bitc = 0;
        fr.delete();
    end

    always @(posedge spi_sck) if (spi_ss === 1'b0) begin
        sh = {sh[6:0], spi_mosi};
        bitc++;
        if (bitc == 8) begin
            bitc = 0;
            fr.push_back(sh);
            if (fr.size() == 4) ad = sh;
            else if (fr.size() > 4) begin
                if (fr[0] == 8'h02) mem[ad] = sh;
                ad = ad + 8'd1;
            end
        end
    end

    always @(negedge spi_sck) if (spi_ss === 1'b0 && fr.size() >= 4 && fr[0] == 8'h03) begin
        cur = mem[ad];
        spi_miso = cur[3'(7 - bitc)];
    end

    // Frame scoreboard: compares each completed (non-aborted) frame
    int         flen_q [$];
    logic [7:0] fbyte_q [$];

    task automatic push_frame(input int n, input logic [63:0] f);
        flen_q.push_back(n);
        for (int k = 0; k < n; k++) fbyte_q.push_back(f[63 - 8*k -: 8]);
    endtask

    always @(posedge spi_ss) if (reset_n === 1'b1) begin
        int n;
        logic [7:0] want;
        if (flen_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected: got %0d-byte frame, want none", fr.size());
        end else begin
            n = flen_q.pop_front();
            chk("frame_len", 32'(fr.size()), 32'(n));
            for (int k = 0; k < n; k++) begin
                want = fbyte_q.pop_front();
                chk($sformatf("frame_byte%0d", k),
                    (k < fr.size()) ? {24'h0, fr[k]} : 32'hFFFF_FFFF, {24'h0, want});
            end
        end
    end

    // Ack scoreboard
    typedef struct {
        string       nm;
        logic [31:0] rd;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q [$];

    always @(negedge clock) if (reset_n && wb_ack) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack (rd_data %h), want none", rd_data);
        end else begin
            e = exp_q.pop_front();
            chk({e.nm, "_rd"}, rd_data, e.rd);
            if (e.lat > 0) chk({e.nm, "_lat"}, 32'(cyc_n - e.t0), 32'(e.lat));
        end
    end

    // Chip-select gap monitor: every frame start must follow >= CS_GAP high cycles
    int   hi_run = 0;
    logic prev_ss = 1'b1;
    always @(negedge clock) if (reset_n) begin
        if (spi_ss === 1'b1) hi_run++;
        else begin
            if (prev_ss === 1'b1) chk("cs_gap_ok", 32'(hi_run >= CS_GAP), 32'd1);
            hi_run = 0;
        end
        prev_ss = spi_ss;
    end

    task automatic wait_ack(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            seen = wb_ack;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_ack_timeout: got no ack in 2000 cycles, want ack", nm);
        end
    endtask

    task automatic issue(input string nm, input logic we, input logic [31:0] a,
                         input logic [3:0] sel, input logic [31:0] d, input logic [31:0] exp_rd,
                         input int lat);
        exp_t e;
        address = a; wr_data = d; wb_sel = sel; wb_we = we; wb_cyc = 1'b1;
        e.nm = nm; e.rd = exp_rd; e.lat = lat; e.t0 = cyc_n;
        exp_q.push_back(e);
    endtask

    task automatic access(input string nm, input logic we, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] d, input logic [31:0] exp_rd,
                          input int lat, input int n, input logic [63:0] f);
        repeat (CS_GAP + 3) @(negedge clock);
        push_frame(n, f);
        issue(nm, we, a, sel, d, exp_rd, lat);
        wait_ack(nm);
        wb_cyc = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ss", {31'h0, spi_ss}, 32'd1);
        chk("rst_sck", {31'h0, spi_sck}, 32'd0);
        chk("rst_ack", {31'h0, wb_ack}, 32'd0);
        chk("rst_rd", rd_data, 32'h0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("idle_ss", {31'h0, spi_ss}, 32'd1);
        chk("idle_sck", {31'h0, spi_sck}, 32'd0);
        chk("idle_mosi", {31'h0, spi_mosi}, 32'd0);

        access("rd10", 1'b0, 32'h10, 4'hF, 32'h0, 32'h44332211, 258, 8, 64'h03000010_00000000);
        access("wrb20", 1'b1, 32'h20, 4'b0100, 32'h00AB0000, 32'h44332211, 162, 5, 64'h02000022_AB000000);
        access("rd20", 1'b0, 32'h20, 4'hF, 32'h0, 32'h00AB0000, 258, 8, 64'h03000020_00000000);
        access("wrh30", 1'b1, 32'h30, 4'b1100, 32'hBEEF0000, 32'h00AB0000, 194, 6, 64'h02000032_EFBE0000);
        access("rd30a", 1'b0, 32'h30, 4'hF, 32'h0, 32'hBEEF0000, 258, 8, 64'h03000030_00000000);
        access("wrw30", 1'b1, 32'h30, 4'hF, 32'hDEADBEEF, 32'hBEEF0000, 258, 8, 64'h02000030_EFBEADDE);
        access("rd30b", 1'b0, 32'h30, 4'hF, 32'h0, 32'hDEADBEEF, 258, 8, 64'h03000030_00000000);
        access("wrb41", 1'b1, 32'h41, 4'b0001, 32'h0000005A, 32'hDEADBEEF, 162, 5, 64'h02000040_5A000000);
        access("rd40", 1'b0, 32'h40, 4'hF, 32'h0, 32'h0000005A, 258, 8, 64'h03000040_00000000);
        access("rdtrunc", 1'b0, 32'hFF000046, 4'hF, 32'h0, 32'h04030201, 258, 8, 64'h03000044_00000000);

        // Back-to-back: wb_cyc stays high; second ack lands CS_GAP cycles after a full word-read latency
        repeat (CS_GAP + 3) @(negedge clock);
        push_frame(8, 64'h03000010_00000000);
        push_frame(8, 64'h03000030_00000000);
        issue("b2b_a", 1'b0, 32'h10, 4'hF, 32'h0, 32'h44332211, 258);
        wait_ack("b2b_a");
        issue("b2b_b", 1'b0, 32'h30, 4'hF, 32'h0, 32'hDEADBEEF, 258 + CS_GAP);
        wait_ack("b2b_b");
        wb_cyc = 1'b0;

        // Reset during the address phase aborts the frame with no ack
        repeat (CS_GAP + 3) @(negedge clock);
        address = 32'h10; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1;
        repeat (75) @(negedge clock);
        chk("pre_abort_ss", {31'h0, spi_ss}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_ss", {31'h0, spi_ss}, 32'd1);
        chk("abort_sck", {31'h0, spi_sck}, 32'd0);
        chk("abort_rd", rd_data, 32'h0);
        @(negedge clock);
        wb_cyc = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (300) @(negedge clock);
        access("rd10_post", 1'b0, 32'h10, 4'hF, 32'h0, 32'h44332211, 258, 8, 64'h03000010_00000000);

        repeat (20) @(negedge clock);
        chk("acks_pending", 32'(exp_q.size()), 32'd0);
        chk("frames_pending", 32'(flen_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
